// File: rtl/hazard_scoreboard_unit.sv
// Hazard scoreboard beside the ID stage.
// Raises a single stall/bubble request for three cases:
//   - load-use hazards, with a multi-cycle load stall;
//   - RAW/WAW hazards against the one in-flight mul/div result;
//   - structural hazards on the non-pipelined mul/div unit.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MD_LATENCY        = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_rs1_used,
  input  logic                  ifid_rs2_used,
  input  logic [REG_ADDR_W-1:0] ifid_rd,
  input  logic                  ifid_reg_write,
  input  logic                  ifid_is_md,
  input  logic                  md_start,
  input  logic [REG_ADDR_W-1:0] md_rd,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  bubble_idex,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [REG_ADDR_W-1:0] md_wb_rd,
  output logic                  load_stall_active
);

  // The detection cycle is one stall cycle, so the counter only covers the rest.
  localparam int LD_CW = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;
  localparam int MD_CW = $clog2(MD_LATENCY);
  localparam logic [LD_CW-1:0] LD_INIT = LD_CW'(LOAD_STALL_CYCLES - 1);
  localparam logic [MD_CW-1:0] MD_INIT = MD_CW'(MD_LATENCY - 1);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  md_state_e             md_state_q, md_state_d;
  logic [MD_CW-1:0]      md_cnt_q, md_cnt_d;
  logic [REG_ADDR_W-1:0] md_wb_rd_q, md_wb_rd_d;
  logic [LD_CW-1:0]      load_cnt_q, load_cnt_d;

  logic load_hazard;
  logic md_hazard;
  logic md_busy_int;
  logic md_last;
  logic stall_req;

  // Hazard detection; the md terms only look at the scoreboard while an op is in flight.
  always_comb begin
    logic wb_nz;
    logic raw;
    logic waw;
    load_hazard = idex_mem_read && (idex_rd != '0) &&
                  ((ifid_rs1_used && (idex_rd == ifid_rs1)) ||
                   (ifid_rs2_used && (idex_rd == ifid_rs2)));
    md_busy_int = (md_state_q == MD_BUSY);
    md_last     = md_busy_int && (md_cnt_q == '0);
    wb_nz       = (md_wb_rd_q != '0);
    raw         = wb_nz && ((ifid_rs1_used && (ifid_rs1 == md_wb_rd_q)) ||
                            (ifid_rs2_used && (ifid_rs2 == md_wb_rd_q)));
    waw         = wb_nz && ifid_reg_write && (ifid_rd == md_wb_rd_q);
    md_hazard   = md_busy_int && (ifid_is_md || raw || waw);
    // Held-reset gating keeps the combinational inputs from leaking through.
    stall_req   = reset_n && (load_hazard || (load_cnt_q != '0) || md_hazard);
  end

  // Next-state for the load stall counter and the mul/div tracker.
  always_comb begin
    load_cnt_d = '0;
    if (flush) begin
      load_cnt_d = '0;
    end else if (load_cnt_q != '0) begin
      load_cnt_d = load_cnt_q - LD_CW'(1);
    end else if (load_hazard) begin
      load_cnt_d = LD_INIT;
    end

    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    md_wb_rd_d = md_wb_rd_q;
    if (flush) begin
      md_state_d = MD_IDLE;
      md_cnt_d   = '0;
      md_wb_rd_d = '0;
    end else begin
      case (md_state_q)
        MD_IDLE: begin
          if (md_start) begin
            md_state_d = MD_BUSY;
            md_cnt_d   = MD_INIT;
            md_wb_rd_d = md_rd;
          end
        end
        MD_BUSY: begin
          // md_start here is ignored, including in the final (done) cycle.
          if (md_cnt_q == '0) begin
            md_state_d = MD_IDLE;
          end else begin
            md_cnt_d = md_cnt_q - MD_CW'(1);
          end
        end
        default: md_state_d = MD_IDLE;
      endcase
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= '0;
      md_wb_rd_q <= '0;
      load_cnt_q <= '0;
    end else begin
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
      md_wb_rd_q <= md_wb_rd_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  // A flushed op must not write back, so its final cycle shows no done pulse.
  assign md_done           = md_last && !flush;
  assign md_busy           = md_busy_int;
  assign md_wb_rd          = md_wb_rd_q;
  assign load_stall_active = (load_cnt_q != '0);
  assign stall_pc          = stall_req;
  assign stall_ifid        = stall_req;
  assign bubble_idex       = stall_req;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit (LOAD_STALL_CYCLES=3, MD_LATENCY=4).
// Stimulus pushes the hand-computed response for each cycle; a monitor pops
// and compares on the falling edge.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       idex_mem_read;
  logic [4:0] idex_rd;
  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic       ifid_rs1_used;
  logic       ifid_rs2_used;
  logic [4:0] ifid_rd;
  logic       ifid_reg_write;
  logic       ifid_is_md;
  logic       md_start;
  logic [4:0] md_rd;
  logic       stall_pc;
  logic       stall_ifid;
  logic       bubble_idex;
  logic       md_busy;
  logic       md_done;
  logic [4:0] md_wb_rd;
  logic       load_stall_active;

  hazard_scoreboard_unit #(
    .REG_ADDR_W(5),
    .LOAD_STALL_CYCLES(3),
    .MD_LATENCY(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .idex_mem_read(idex_mem_read),
    .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1),
    .ifid_rs2(ifid_rs2),
    .ifid_rs1_used(ifid_rs1_used),
    .ifid_rs2_used(ifid_rs2_used),
    .ifid_rd(ifid_rd),
    .ifid_reg_write(ifid_reg_write),
    .ifid_is_md(ifid_is_md),
    .md_start(md_start),
    .md_rd(md_rd),
    .stall_pc(stall_pc),
    .stall_ifid(stall_ifid),
    .bubble_idex(bubble_idex),
    .md_busy(md_busy),
    .md_done(md_done),
    .md_wb_rd(md_wb_rd),
    .load_stall_active(load_stall_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic       busy;
    logic       done;
    logic       lsa;
    logic       wb_chk;
    logic [4:0] wb;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = exp_q.pop_front();
      ok = (stall_pc == e.stall) && (stall_ifid == e.stall) && (bubble_idex == e.stall) &&
           (md_busy == e.busy) && (md_done == e.done) && (load_stall_active == e.lsa) &&
           (!e.wb_chk || (md_wb_rd == e.wb));
      n_vec++;
      if (!ok) begin
        n_miss++;
        $display("FAIL %s: got pc/ifid/bub=%b%b%b busy=%b done=%b lsa=%b wb=%0d, want stall=%b busy=%b done=%b lsa=%b wb=%0d(chk=%b)",
                 e.name, stall_pc, stall_ifid, bubble_idex, md_busy, md_done,
                 load_stall_active, md_wb_rd, e.stall, e.busy, e.done, e.lsa, e.wb, e.wb_chk);
      end
    end
  end

  task automatic idle_in();
    flush          = 1'b0;
    idex_mem_read  = 1'b0;
    idex_rd        = '0;
    ifid_rs1       = '0;
    ifid_rs2       = '0;
    ifid_rs1_used  = 1'b0;
    ifid_rs2_used  = 1'b0;
    ifid_rd        = '0;
    ifid_reg_write = 1'b0;
    ifid_is_md     = 1'b0;
    md_start       = 1'b0;
    md_rd          = '0;
  endtask

  // Push the expected response for the inputs just driven, then advance a cycle.
  task automatic cyc(input string name, input logic s, input logic b, input logic d,
                     input logic l, input logic wc, input logic [4:0] w);
    exp_t e;
    e.name = name; e.stall = s; e.busy = b; e.done = d; e.lsa = l; e.wb_chk = wc; e.wb = w;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [4:0] r);
    idle_in();
    ifid_rs1      = r;
    ifid_rs1_used = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_in();
    @(posedge clk);
    #1;

    // Reset holds everything low, even with a live load-use pattern on the inputs.
    cyc("reset_idle", 0, 0, 0, 0, 1, 5'd0);
    idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; ifid_rs1_used = 1; md_start = 1; md_rd = 7;
    cyc("reset_inputs_live", 0, 0, 0, 0, 1, 5'd0);
    reset_n = 1'b1;
    idle_in();
    cyc("post_reset", 0, 0, 0, 0, 1, 5'd0);

    // Load-use through rs2: three stall cycles in total.
    idle_in(); idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_rs2_used = 1;
    cyc("ld_rs2_detect", 1, 0, 0, 0, 1, 5'd0);
    idle_in();
    cyc("ld_rs2_cnt2", 1, 0, 0, 1, 1, 5'd0);
    cyc("ld_rs2_cnt1", 1, 0, 0, 1, 1, 5'd0);
    cyc("ld_rs2_release", 0, 0, 0, 0, 1, 5'd0);

    // Unused rs2 and x0 destination never stall.
    idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_rs2_used = 0; ifid_rs1 = 3; ifid_rs1_used = 1;
    cyc("ld_rs2_unused", 0, 0, 0, 0, 1, 5'd0);
    idle_in(); idex_mem_read = 1; idex_rd = 0; ifid_rs1 = 0; ifid_rs1_used = 1;
    cyc("ld_rd_x0", 0, 0, 0, 0, 1, 5'd0);

    // Load-use through rs1, flushed while the counter is at 2.
    idle_in(); idex_mem_read = 1; idex_rd = 6; ifid_rs1 = 6; ifid_rs1_used = 1;
    cyc("ld_rs1_detect", 1, 0, 0, 0, 1, 5'd0);
    idle_in(); flush = 1;
    cyc("ld_flush_cycle", 1, 0, 0, 1, 1, 5'd0);
    idle_in();
    cyc("ld_after_flush", 0, 0, 0, 0, 1, 5'd0);

    // RAW on x7 against a 4-cycle op.
    idle_in(); md_start = 1; md_rd = 7;
    cyc("md_raw_issue", 0, 0, 0, 0, 1, 5'd0);
    rd_reg(7); cyc("md_raw_b1", 1, 1, 0, 0, 1, 5'd7);
    rd_reg(7); cyc("md_raw_b2", 1, 1, 0, 0, 1, 5'd7);
    rd_reg(7); cyc("md_raw_b3", 1, 1, 0, 0, 1, 5'd7);
    rd_reg(7); cyc("md_raw_done", 1, 1, 1, 0, 1, 5'd7);
    rd_reg(7); cyc("md_raw_release", 0, 0, 0, 0, 0, 5'd0);

    // Unrelated register, then a structural hazard; md_start in the done cycle is ignored.
    idle_in(); md_start = 1; md_rd = 7;
    cyc("md_st_issue", 0, 0, 0, 0, 1, 5'd7);
    rd_reg(8); cyc("md_st_rs_x8", 0, 1, 0, 0, 1, 5'd7);
    idle_in(); ifid_is_md = 1; cyc("md_st_b2", 1, 1, 0, 0, 1, 5'd7);
    idle_in(); ifid_is_md = 1; cyc("md_st_b3", 1, 1, 0, 0, 1, 5'd7);
    idle_in(); ifid_is_md = 1; md_start = 1; md_rd = 3;
    cyc("md_st_done", 1, 1, 1, 0, 1, 5'd7);
    idle_in(); ifid_is_md = 1;
    cyc("md_st_start_in_done_ignored", 0, 0, 0, 0, 0, 5'd0);

    // WAW on x9 with no sources read.
    idle_in(); md_start = 1; md_rd = 9;
    cyc("md_waw_issue", 0, 0, 0, 0, 0, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      idle_in(); ifid_reg_write = 1; ifid_rd = 9;
      cyc($sformatf("md_waw_b%0d", i), 1, 1, (i == 4), 0, 1, 5'd9);
    end
    idle_in(); ifid_reg_write = 1; ifid_rd = 9;
    cyc("md_waw_release", 0, 0, 0, 0, 0, 5'd0);

    // md_rd = x0: only structural stalls; md_start while busy is ignored.
    idle_in(); md_start = 1; md_rd = 0;
    cyc("md_x0_issue", 0, 0, 0, 0, 0, 5'd0);
    idle_in(); ifid_rs1 = 0; ifid_rs1_used = 1; ifid_reg_write = 1; ifid_rd = 0;
    cyc("md_x0_no_raw_waw", 0, 1, 0, 0, 1, 5'd0);
    idle_in(); ifid_is_md = 1; md_start = 1; md_rd = 4;
    cyc("md_x0_struct", 1, 1, 0, 0, 1, 5'd0);
    rd_reg(4); cyc("md_x0_busy_start_ignored", 0, 1, 0, 0, 1, 5'd0);
    idle_in(); cyc("md_x0_done", 0, 1, 1, 0, 1, 5'd0);
    idle_in(); cyc("md_x0_idle", 0, 0, 0, 0, 0, 5'd0);

    // Flush in busy cycle 2: no done pulse afterwards.
    idle_in(); md_start = 1; md_rd = 7;
    cyc("md_fl_issue", 0, 0, 0, 0, 0, 5'd0);
    rd_reg(7); cyc("md_fl_b1", 1, 1, 0, 0, 1, 5'd7);
    rd_reg(7); flush = 1; cyc("md_fl_flush_cycle", 1, 1, 0, 0, 1, 5'd7);
    rd_reg(7); cyc("md_fl_after", 0, 0, 0, 0, 1, 5'd0);
    rd_reg(7); cyc("md_fl_no_done_a", 0, 0, 0, 0, 1, 5'd0);
    rd_reg(7); cyc("md_fl_no_done_b", 0, 0, 0, 0, 1, 5'd0);

    // Flush outranks a simultaneous md_start.
    idle_in(); flush = 1; md_start = 1; md_rd = 7;
    cyc("fl_vs_start", 0, 0, 0, 0, 1, 5'd0);
    rd_reg(7); cyc("fl_vs_start_after", 0, 0, 0, 0, 1, 5'd0);

    // Load and md hazards together, then async reset in the middle of both.
    idle_in(); md_start = 1; md_rd = 7; idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_rs2_used = 1;
    cyc("both_detect", 1, 0, 0, 0, 1, 5'd0);
    rd_reg(7); cyc("both_busy_cnt2", 1, 1, 0, 1, 1, 5'd7);
    rd_reg(7); idex_mem_read = 1; idex_rd = 7; reset_n = 1'b0;
    cyc("async_reset_mid", 0, 0, 0, 0, 1, 5'd0);
    reset_n = 1'b1; idle_in();
    cyc("after_reset_release", 0, 0, 0, 0, 1, 5'd0);
    idle_in(); md_start = 1; md_rd = 2;
    cyc("rst_md_issue", 0, 0, 0, 0, 1, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      idle_in(); ifid_rs2 = 2; ifid_rs2_used = 1;
      cyc($sformatf("rst_md_b%0d", i), 1, 1, (i == 4), 0, 1, 5'd2);
    end
    idle_in(); ifid_rs2 = 2; ifid_rs2_used = 1;
    cyc("rst_md_release", 0, 0, 0, 0, 0, 5'd0);

    // Every pushed record must have been consumed by the monitor.
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
